// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the multiply, divide and SQRT datapaths.
package fp_pkg;

    localparam int          FP_EXP_W   = 8;
    localparam int          FP_MANT_W  = 23;
    localparam int          FP_BIAS    = 127;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP_INF_EXP = 8'hFF;

    // Exponent arithmetic width: wide enough that sums/increments never wrap.
    localparam int          FP_EXPC_W  = 10;

    typedef enum logic [1:0] {
        FPC_ZERO,
        FPC_NORM,
        FPC_INF,
        FPC_NAN
    } fpClass_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        PACK
    } mulState_t;

endpackage

// File: rtl/fp_mul_seq_if.sv
// Start/busy/done handshake bundle between a requester and the sequential multiplier.
interface fp_mul_seq_if;

    logic        start;
    logic [31:0] data_iA;
    logic [31:0] data_iB;
    logic        busy;
    logic        done;
    logic [31:0] data_o;

    modport master (
        output start, data_iA, data_iB,
        input  busy, done, data_o
    );

    modport slave (
        input  start, data_iA, data_iB,
        output busy, done, data_o
    );

endinterface

// File: rtl/fp_classify.sv
// Combinational operand decoder: sign, class and 24-bit mantissa with hidden bit.
// Subnormals are flushed to zero.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]        operand,
    output logic               opSign,
    output fpClass_t           opClass,
    output logic [FP_MANT_W:0] opMant
);

    logic [FP_EXP_W-1:0]  expField;
    logic [FP_MANT_W-1:0] fracField;

    assign opSign    = operand[31];
    assign expField  = operand[30:23];
    assign fracField = operand[22:0];

    // Classify the operand and prepend the hidden bit for normal numbers.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        opClass = FPC_NORM;
        opMant  = {1'b1, fracField};
        if (expField == '0) begin
            opClass = FPC_ZERO;
            opMant  = '0;
        end else if (expField == FP_INF_EXP) begin
            opClass = (fracField == '0) ? FPC_INF : FPC_NAN;
            opMant  = '0;
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: radix-2 shift-add mantissa
// core, normalise, round-to-nearest-even, pack. Fixed 26-clock latency.
module fp_mul_seq
    import fp_pkg::*;
#(
    parameter int MANT_W   = FP_MANT_W,
    parameter int EXP_BIAS = FP_BIAS
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_mul_seq_if.slave  bus
);

    localparam int SIG_W  = MANT_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int EW     = FP_EXPC_W;

    // Operand decode (combinational, sampled on the accepted start edge)
    logic             signA, signB;
    fpClass_t         classA, classB;
    logic [SIG_W-1:0] mantA, mantB;
    logic signed [EW-1:0] expSum;

    // Control and datapath state
    mulState_t         state;
    logic [4:0]        cnt;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] mcand;
    logic [SIG_W-1:0]  mplier;
    logic              resSign;
    fpClass_t          regClassA, regClassB;
    logic signed [EW-1:0] expReg;
    logic [SIG_W-1:0]  normMant;
    logic              guardBit;
    logic              stickyBit;
    logic              busyReg;
    logic              doneReg;
    logic [31:0]       dataReg;

    // Rounding / packing
    logic              roundUp;
    logic [SIG_W:0]    roundMant;
    logic signed [EW-1:0] finalExp;
    logic [MANT_W-1:0] fracOut;
    logic [31:0]       packWord;

    fp_classify u_classA (
        .operand (bus.data_iA),
        .opSign  (signA),
        .opClass (classA),
        .opMant  (mantA)
    );

    fp_classify u_classB (
        .operand (bus.data_iB),
        .opSign  (signB),
        .opClass (classB),
        .opMant  (mantB)
    );

    assign expSum = $signed({2'b00, bus.data_iA[30:23]})
                  + $signed({2'b00, bus.data_iB[30:23]})
                  - EW'(EXP_BIAS);

    assign bus.busy   = busyReg;
    assign bus.done   = doneReg;
    assign bus.data_o = dataReg;

    // Round to nearest-even, renormalise on carry-out, then apply special-case priority.
    always_comb begin
        roundUp   = guardBit & (stickyBit | normMant[0]);
        roundMant = {1'b0, normMant} + {{SIG_W{1'b0}}, roundUp};
        finalExp  = roundMant[SIG_W] ? expReg + EW'(1) : expReg;
        // On carry-out the rounded value is exactly 2^24, so its fraction is roundMant[23:1] (all zero).
        fracOut   = roundMant[SIG_W] ? roundMant[SIG_W-1:1] : roundMant[SIG_W-2:0];
        packWord  = {resSign, finalExp[FP_EXP_W-1:0], fracOut};

        if (regClassA == FPC_NAN || regClassB == FPC_NAN) begin
            packWord = FP_QNAN;
        end else if ((regClassA == FPC_INF && regClassB == FPC_ZERO) ||
                     (regClassA == FPC_ZERO && regClassB == FPC_INF)) begin
            packWord = FP_QNAN;
        end else if (regClassA == FPC_INF || regClassB == FPC_INF) begin
            packWord = {resSign, FP_INF_EXP, {MANT_W{1'b0}}};
        end else if (regClassA == FPC_ZERO || regClassB == FPC_ZERO) begin
            packWord = {resSign, 31'h0};
        end else if (finalExp >= EW'(255)) begin
            packWord = {resSign, FP_INF_EXP, {MANT_W{1'b0}}};
        end else if (finalExp <= EW'(0)) begin
            packWord = {resSign, 31'h0};
        end
    end

    // Control FSM and datapath: capture, shift-add, normalise, register result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so an aborted operation leaves no stale product behind.
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            resSign   <= 1'b0;
            regClassA <= FPC_ZERO;
            regClassB <= FPC_ZERO;
            expReg    <= '0;
            normMant  <= '0;
            guardBit  <= 1'b0;
            stickyBit <= 1'b0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            dataReg   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc       <= '0;
                        mcand     <= {{SIG_W{1'b0}}, mantA};
                        mplier    <= mantB;
                        cnt       <= '0;
                        resSign   <= signA ^ signB;
                        expReg    <= expSum;
                        regClassA <= classA;
                        regClassB <= classB;
                        busyReg   <= 1'b1;
                        state     <= MUL;
                    end
                end
                MUL: begin
                    acc    <= acc + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'(SIG_W - 1)) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (acc[PROD_W-1]) begin
                        normMant  <= acc[PROD_W-1 -: SIG_W];
                        guardBit  <= acc[PROD_W-SIG_W-1];
                        stickyBit <= |acc[PROD_W-SIG_W-2:0];
                        expReg    <= expReg + EW'(1);
                    end else begin
                        normMant  <= acc[PROD_W-2 -: SIG_W];
                        guardBit  <= acc[PROD_W-SIG_W-2];
                        stickyBit <= |acc[PROD_W-SIG_W-3:0];
                    end
                    busyReg <= 1'b0;
                    state   <= PACK;
                end
                PACK: begin
                    dataReg <= packWord;
                    doneReg <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed testbench for fp_mul_seq: scoreboard of expected products,
// latency/busy-width checks and handshake corner cases.
module tb_fp_mul_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   startCyc = 0;
    logic [31:0] sb[$];

    fp_mul_seq_if bus();

    fp_mul_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no summary expected=summary before time limit");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expV);
        total++;
        assert (obs === expV) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expV);
        end
    endtask

    // Drive a request at the current negedge; the following posedge accepts it.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expV);
        bus.start   = 1'b1;
        bus.data_iA = a;
        bus.data_iB = b;
        sb.push_back(expV);
        startCyc = cyc;
    endtask

    // Wait (bounded) for done; optionally pulse start once at sample index glitchAt.
    task automatic awaitDone(input string tag, input int glitchAt);
        int          busyCnt = 0;
        bit          got = 1'b0;
        logic [31:0] expV;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_done_low"}, 32'(bus.done), 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) busyCnt++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (i == glitchAt) begin
                bus.start   = 1'b1;
                bus.data_iA = 32'h3FC0_0000;
                bus.data_iB = 32'h3FC0_0000;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        expV = sb.pop_front();
        check({tag, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_latency"}, cyc - startCyc - 1, 32'd26);
            check({tag, "_busy"}, busyCnt, 32'd25);
            check({tag, "_data"}, bus.data_o, expV);
        end
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expV);
        @(negedge clk);
        launch(a, b, expV);
        awaitDone(tag, -1);
    endtask

    // Watch n cycles: no done pulse, data_o holds expData.
    task automatic checkQuiet(input string tag, input int n, input logic [31:0] expData);
        int pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check({tag, "_no_done"}, pulses, 32'd0);
        check({tag, "_hold"}, bus.data_o, expData);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.data_iA = '0;
        bus.data_iB = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_data", bus.data_o, 32'd0);
        rst_n = 1'b1;

        // Main function, rounding and normalise paths
        runOp("mul_2x3",      32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        runOp("mul_1p5sq",    32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
        runOp("mul_neg",      32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000);
        runOp("rne_sticky",   32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
        runOp("rne_up",       32'h3F80_0001, 32'h3FC0_0001, 32'h3FC0_0003);
        runOp("rne_tie_odd",  32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002);
        runOp("rne_tie_even", 32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004);
        runOp("mul_big",      32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE);

        // Range limits and special operands
        runOp("overflow",     32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000);
        runOp("underflow",    32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
        runOp("signed_zero",  32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);
        runOp("inf_x_zero",   32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
        runOp("nan_in",       32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
        runOp("neg_inf",      32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
        runOp("subnorm_ftz",  32'h0000_0001, 32'h4000_0000, 32'h0000_0000);

        // start while busy (mid-MUL, then during PACK) is ignored
        @(negedge clk);
        launch(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        awaitDone("glitch_mul", 10);
        checkQuiet("glitch_mul", 35, 32'h40C0_0000);
        @(negedge clk);
        launch(32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000);
        awaitDone("glitch_pack", 25);
        checkQuiet("glitch_pack", 35, 32'hBF80_0000);

        // start in the done cycle is accepted
        @(negedge clk);
        launch(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        awaitDone("chain_first", -1);
        launch(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
        awaitDone("chain_second", -1);

        // Reset during MUL aborts without a done pulse and clears data_o
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_iA = 32'h4000_0000;
        bus.data_iB = 32'h4040_0000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_data", bus.data_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkQuiet("abort", 40, 32'd0);

        // Operation after an abort
        runOp("recover", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
